// File: rtl/spi_reader.sv
// -----------------------------------------------------------------------------
// spi_reader
//
// Receive-only SPI slave, mode 0, MSB first. The CS_N, SCLK and MOSI pins are
// brought into the CLK domain through a 2-flop synchronizer. A further flop
// on the synchronized SCLK detects its rising edges, and MOSI is sampled on
// each of those edges while CS_N is low. Each completed byte is pushed into a
// small receive buffer. A ready/enable handshake drains the buffer.
//
// Configuration:
//   SPI_READER_FIFO_EN  defined   -> the buffer is a 4-entry FIFO
//                       undefined -> the buffer is one holding register
//
// Ports:
//   CLK       in   system clock; all state changes on its rising edge
//   RST       in   synchronous, active-high reset
//   spi[2:0]  in   {CS_N, SCLK, MOSI}, asynchronous to CLK
//   read[7:0] out  oldest buffered byte; reads as 0x00 while RDY_read=0
//   RDY_read  out  at least one byte is buffered
//   EN_read   in   consumer takes the head byte this cycle
//   overrun   out  sticky: a completed byte arrived at a full buffer and was
//                  lost; only reset clears it
// -----------------------------------------------------------------------------
module spi_reader (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] spi,
    output logic [7:0] read,
    output logic       RDY_read,
    input  logic       EN_read,
    output logic       overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state;
    logic [2:0] sync1, sync2;
    logic       sclk_prev;
    logic [1:0] sync_vld;   // marks when sync2 holds a real pin sample
    logic       armed;      // CS_N has been seen high since reset
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    logic       cs_n, sclk, mosi;
    logic       sclk_rise;
    logic       byte_done;
    logic [7:0] byte_data;
    logic       full;
    logic       pop;
    logic       push_ok;

    assign cs_n      = sync2[2];
    assign sclk      = sync2[1];
    assign mosi      = sync2[0];
    assign sclk_rise = sclk & ~sclk_prev;
    assign byte_data = {shreg[6:0], mosi};
    assign byte_done = (state == SHIFT) && !cs_n && sclk_rise && (bit_cnt == 3'd7);

    assign pop       = EN_read && RDY_read;
    // A pop in the same cycle frees the slot the new byte needs.
    assign push_ok   = byte_done && (!full || pop);

    // Synchronizer, edge detect and receive FSM.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // values from before the edge, whatever the order of the statements.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1     <= 3'b100;
            sync2     <= 3'b100;
            sclk_prev <= 1'b0;
            sync_vld  <= 2'b00;
            armed     <= 1'b0;
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
        end else begin
            sync1     <= spi;
            sync2     <= sync1;
            sclk_prev <= sclk;
            sync_vld  <= {sync_vld[0], 1'b1};
            // The reset value of sync2 says CS_N=1. Until a genuine high
            // sample is seen, a CS_N that stayed low across a reset is not
            // treated as a new falling edge.
            if (sync_vld[1] && cs_n) armed <= 1'b1;

            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    shreg   <= 8'h00;
                    if (armed && !cs_n) state <= SHIFT;
                end
                SHIFT: begin
                    if (cs_n) begin
                        // A partial byte is discarded. The buffer is untouched.
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                    end else if (sclk_rise) begin
                        shreg   <= byte_data;
                        bit_cnt <= bit_cnt + 3'd1;   // wraps 7->0 at byte end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READER_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    assign full     = (count == 3'd4);
    assign RDY_read = (count != 3'd0);
    assign read     = RDY_read ? mem[rd_ptr] : 8'h00;

    // NOTE: the storage array has no reset. Occupancy is tracked by count,
    // and read is gated, so a stale entry is never visible.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= byte_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       hold_vld;

    assign full     = hold_vld;
    assign RDY_read = hold_vld;
    assign read     = hold_vld ? hold : 8'h00;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold     <= 8'h00;
            hold_vld <= 1'b0;
        end else if (push_ok) begin
            hold     <= byte_data;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST)                          overrun <= 1'b0;
        else if (byte_done && full && !pop) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_spi_reader.sv
// -----------------------------------------------------------------------------
// tb_spi_reader
//
// Directed bench for spi_reader. It drives the SPI pins on the falling edge of
// CLK, holding each SCLK phase for 3 CLK cycles. Outputs are sampled on the
// falling edge. Expected bytes are written out by hand.
// -----------------------------------------------------------------------------
module tb_spi_reader;

`ifdef SPI_READER_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN_read;
    logic       cs_n, sclk, mosi;
    logic [2:0] spi;
    logic [7:0] read;
    logic       RDY_read;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    assign spi = {cs_n, sclk, mosi};

    spi_reader dut (
        .CLK      (CLK),
        .RST      (RST),
        .spi      (spi),
        .read     (read),
        .RDY_read (RDY_read),
        .EN_read  (EN_read),
        .overrun  (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        EN_read = 1'b0;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        wait_n(2);
        RST = 1'b0;
        wait_n(4);
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        wait_n(4);
    endtask

    task automatic end_frame();
        sclk = 1'b0;
        wait_n(3);
        cs_n = 1'b1;
        wait_n(4);
    endtask

    // If pop_at_edge is set, EN_read is high exactly in the cycle where the
    // rise of SCLK is detected. That is the push cycle when this is the 8th bit.
    task automatic send_bit(input logic b, input logic pop_at_edge);
        sclk = 1'b0;
        mosi = b;
        wait_n(3);
        sclk = 1'b1;
        wait_n(2);
        if (pop_at_edge) EN_read = 1'b1;
        wait_n(1);
        EN_read = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic pop_at_done);
        for (int i = 7; i >= 0; i--) send_bit(d[i], pop_at_done && (i == 0));
    endtask

    task automatic pop_one();
        EN_read = 1'b1;
        wait_n(1);
        EN_read = 1'b0;
    endtask

    task automatic expect_head_pop(input string tag, input logic [7:0] exp);
        check({tag, "_rdy"}, {7'd0, RDY_read}, 8'h01);
        check(tag, read, exp);
        pop_one();
    endtask

    initial begin
        logic [7:0] d;
        int         nbuf;

        // Reset state
        do_reset();
        check("rst_rdy", {7'd0, RDY_read}, 8'h00);
        check("rst_read", read, 8'h00);
        check("rst_overrun", {7'd0, overrun}, 8'h00);

        // Single byte 0x65: RDY_read rises exactly one cycle after the 8th edge
        d = 8'h65;
        start_frame();
        for (int i = 7; i >= 1; i--) send_bit(d[i], 1'b0);
        sclk = 1'b0;
        mosi = d[0];
        wait_n(3);
        sclk = 1'b1;
        wait_n(2);   // the rise is now visible at the synchronizer output
        check("t1_rdy_at_edge", {7'd0, RDY_read}, 8'h00);
        wait_n(1);
        check("t1_rdy_after_edge", {7'd0, RDY_read}, 8'h01);
        check("t1_read", read, 8'h65);
        end_frame();
        check("t1_rdy_held", {7'd0, RDY_read}, 8'h01);
        pop_one();
        check("t1_rdy_after_pop", {7'd0, RDY_read}, 8'h00);

        // Two bytes in one frame, consumer reads both
        start_frame();
        send_byte(8'h65, 1'b0);
        expect_head_pop("t2_b0", 8'h65);
        send_byte(8'h0A, 1'b0);
        expect_head_pop("t2_b1", 8'h0A);
        end_frame();
        check("t2_overrun", {7'd0, overrun}, 8'h00);
        check("t2_empty", {7'd0, RDY_read}, 8'h00);

        // Partial byte of ones is discarded; the next byte has no stale bits
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        end_frame();
        check("t3_partial_rdy", {7'd0, RDY_read}, 8'h00);
        start_frame();
        send_byte(8'h0A, 1'b0);
        end_frame();
        expect_head_pop("t3_byte", 8'h0A);
        check("t3_overrun", {7'd0, overrun}, 8'h00);

        // Overflow with no reads: the last byte is dropped and overrun is set
        do_reset();
        start_frame();
        for (int k = 0; k <= DEPTH; k++) send_byte(8'((k + 1) * 17), 1'b0);
        end_frame();
        check("t4_overrun", {7'd0, overrun}, 8'h01);
        check("t4_head", read, 8'h11);
        for (int k = 0; k < DEPTH; k++) expect_head_pop("t4_drain", 8'((k + 1) * 17));
        check("t4_empty", {7'd0, RDY_read}, 8'h00);
        check("t4_overrun_sticky", {7'd0, overrun}, 8'h01);

        // Full buffer, pop coincides with byte completion: no overrun
        do_reset();
        start_frame();
        for (int k = 0; k < DEPTH; k++) send_byte(8'((k + 1) * 17), 1'b0);
        send_byte(8'h77, 1'b1);
        end_frame();
        check("t4b_overrun", {7'd0, overrun}, 8'h00);
        for (int k = 1; k < DEPTH; k++) expect_head_pop("t4b_drain", 8'((k + 1) * 17));
        expect_head_pop("t4b_last", 8'h77);
        check("t4b_empty", {7'd0, RDY_read}, 8'h00);

        // Reset mid-byte with data buffered
        do_reset();
        nbuf = (DEPTH < 2) ? DEPTH : 2;
        start_frame();
        for (int k = 0; k < nbuf; k++) send_byte(8'h5A ^ 8'(k), 1'b0);
        check("t5_pre_rdy", {7'd0, RDY_read}, 8'h01);
        d = 8'hA5;
        for (int i = 7; i >= 4; i--) send_bit(d[i], 1'b0);
        RST = 1'b1;
        wait_n(1);
        RST = 1'b0;
        check("t5_rdy", {7'd0, RDY_read}, 8'h00);
        check("t5_overrun", {7'd0, overrun}, 8'h00);
        check("t5_read", read, 8'h00);
        // CS_N never went high, so these bits must be ignored
        send_byte(8'hFF, 1'b0);
        wait_n(4);
        check("t5_no_fresh_edge", {7'd0, RDY_read}, 8'h00);
        end_frame();
        start_frame();
        send_byte(8'hA5, 1'b0);
        end_frame();
        expect_head_pop("t5_a5", 8'hA5);
        check("t5_empty", {7'd0, RDY_read}, 8'h00);

        // SCLK activity with CS_N high is ignored
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mosi = 1'(i);
            sclk = ~sclk;
            wait_n(3);
        end
        check("t6_rdy", {7'd0, RDY_read}, 8'h00);
        check("t6_overrun", {7'd0, overrun}, 8'h00);
        start_frame();
        send_byte(8'hC3, 1'b0);
        end_frame();
        expect_head_pop("t6_c3", 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
